// File: rtl/alct_adc_scanner.sv
// Scans NCH channels of a serial ADC. Results are pipelined: each transaction
// shifts in the conversion started by the previous command, so a scan needs NCH+1.
module alct_adc_scanner #(
  parameter int NCH      = 11,
  parameter int SCK_HALF = 2,
  parameter int T_CSS    = 2,
  parameter int EOC_MIN  = 4,
  parameter int EOC_TMO  = 1024
) (
  input  logic        clock_mez,
  input  logic        nrst,
  input  logic        start,
  input  logic        continuous,
  output logic        busy,
  output logic        done,
  output logic        err_tmo,
  input  logic        err_clr,
  input  logic [3:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        adc_ncs,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  input  logic        adc_eoc
);

  localparam int CW = $clog2(T_CSS + SCK_HALF + EOC_MIN + EOC_TMO + 1);
  localparam logic [CW-1:0] CSS_LAST  = CW'(T_CSS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCK_HALF - 1);
  localparam logic [CW-1:0] EOC_ARM   = CW'(EOC_MIN);
  localparam logic [CW-1:0] TMO_LAST  = CW'(EOC_MIN + EOC_TMO - 1);
  localparam logic [3:0]    K_LAST    = 4'(NCH);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, WAIT_EOC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    bit_q, bit_d;
  logic [11:0]   cmd_q, cmd_d;
  logic [11:0]   din_q, din_d;
  logic          ncs_q, ncs_d;
  logic          sck_q, sck_d;
  logic          sdi_q, sdi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [11:0]   rd_q, rd_d;
  logic [11:0]   result_q [NCH];

  logic          wr_en;
  logic [3:0]    wr_idx;
  logic          tmo;
  logic [3:0]    k_nx;
  logic [11:0]   nx_cmd;

  function automatic logic [11:0] cmd_word(input logic [3:0] k);
    return (k < K_LAST) ? {k, 8'h00} : '0;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    din_d   = din_q;
    ncs_d   = ncs_q;
    sck_d   = sck_q;
    sdi_d   = sdi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = k_q - 4'd1;
    tmo     = 1'b0;
    k_nx    = (state_q == IDLE) ? 4'd0 : k_q + 4'd1;
    nx_cmd  = cmd_word(k_nx);

    unique case (state_q)
      IDLE: begin
        if (start || (continuous && done_q)) begin
          state_d = CS_SETUP;
          cnt_d   = '0;
          k_d     = k_nx;
          busy_d  = 1'b1;
          ncs_d   = 1'b0;
          cmd_d   = nx_cmd;
          sdi_d   = nx_cmd[11];
        end
      end
      CS_SETUP: begin
        if (cnt_q == CSS_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            din_d = {din_q[10:0], adc_sdo};
          end else if (bit_q == 4'd11) begin
            // 12th falling edge closes the frame; din_q already holds all 12 bits
            state_d = WAIT_EOC;
            ncs_d   = 1'b1;
            sck_d   = 1'b0;
            sdi_d   = 1'b0;
            wr_en   = (k_q != 4'd0);
          end else begin
            bit_d = bit_q + 4'd1;
            cmd_d = {cmd_q[10:0], 1'b0};
            sdi_d = cmd_q[10];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_EOC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= EOC_ARM && (adc_eoc || cnt_q == TMO_LAST)) begin
          tmo   = ~adc_eoc;
          cnt_d = '0;
          if (k_q == K_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = CS_SETUP;
            k_d     = k_nx;
            ncs_d   = 1'b0;
            cmd_d   = nx_cmd;
            sdi_d   = nx_cmd[11];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    rd_d = (rd_addr < K_LAST) ? result_q[rd_addr] : '0;
  end

  always_ff @(posedge clock_mez) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      bit_q   <= '0;
      cmd_q   <= '0;
      din_q   <= '0;
      ncs_q   <= 1'b1;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      ncs_q   <= ncs_d;
      sck_q   <= sck_d;
      sdi_q   <= sdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clock_mez) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        result_q[i] <= '0;
      end
    end else if (wr_en) begin
      result_q[wr_idx] <= din_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_tmo = err_q;
  assign rd_data = rd_q;
  assign adc_ncs = ncs_q;
  assign adc_sck = sck_q;
  assign adc_sdi = sdi_q;

endmodule

// File: tb/tb_alct_adc_scanner.sv
// Scoreboard bench: stimulus queues expected scans, commands, timeouts and reads;
// an ADC model and a monitor consume them as the scanner produces activity.
module tb_alct_adc_scanner;

  localparam int NCH      = 11;
  localparam int SCK_HALF = 2;
  localparam int T_CSS    = 2;
  localparam int EOC_MIN  = 4;
  localparam int EOC_TMO  = 1024;
  localparam int TX_BASE  = T_CSS + 24 * SCK_HALF + EOC_MIN;

  logic        clock_mez = 1'b0;
  logic        nrst, start, continuous, err_clr;
  logic [3:0]  rd_addr;
  logic        busy, done, err_tmo;
  logic [11:0] rd_data;
  logic        adc_ncs, adc_sck, adc_sdi;
  logic        adc_sdo = 1'b0;
  logic        adc_eoc = 1'b0;

  always #5 clock_mez = ~clock_mez;

  alct_adc_scanner #(
    .NCH(NCH), .SCK_HALF(SCK_HALF), .T_CSS(T_CSS), .EOC_MIN(EOC_MIN), .EOC_TMO(EOC_TMO)
  ) dut (
    .clock_mez(clock_mez), .nrst(nrst), .start(start), .continuous(continuous),
    .busy(busy), .done(done), .err_tmo(err_tmo), .err_clr(err_clr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .adc_ncs(adc_ncs), .adc_sck(adc_sck), .adc_sdi(adc_sdi),
    .adc_sdo(adc_sdo), .adc_eoc(adc_eoc)
  );

  typedef struct { int len; int gap; } scan_t;
  typedef struct { int addr; logic [11:0] val; } rd_t;

  int    checks = 0;
  int    errors = 0;
  scan_t exp_scan_q[$];
  int    exp_cmd_q[$];
  int    exp_tmo_q[$];
  rd_t   rd_exp_q[$];
  logic [11:0] exp_res [16];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endfunction

  // ADC model: conversion results are served one transaction late
  logic [11:0] adc_val [16];
  int          eoc_delay = 10;
  int          stuck_abs = -100;
  int          tx_cnt = 0;
  int          nbits = 0;
  int          wcnt = 0;
  logic [11:0] sh_out = '0;
  logic [11:0] cmd_sr = '0;
  logic [3:0]  conv_addr = '0;
  logic        ncs_prev = 1'b1;
  logic        sck_prev = 1'b0;

  always @(negedge clock_mez) begin
    if (!adc_ncs && ncs_prev) begin
      sh_out  = adc_val[conv_addr];
      adc_sdo = sh_out[11];
      nbits   = 0;
      cmd_sr  = '0;
    end else if (!adc_ncs) begin
      if (adc_sck && !sck_prev) begin
        cmd_sr = {cmd_sr[10:0], adc_sdi};
        nbits++;
      end
      if (!adc_sck && sck_prev) begin
        sh_out  = {sh_out[10:0], 1'b0};
        adc_sdo = sh_out[11];
      end
    end
    if (adc_ncs && !ncs_prev) begin
      wcnt = 0;
      if (nbits == 12) begin
        if (exp_cmd_q.size() == 0) fail_now("cmd_addr: unexpected transaction");
        else check("cmd_addr", cmd_sr[11:8], exp_cmd_q.pop_front());
        check("cmd_pad", cmd_sr[7:0], 0);
        conv_addr = cmd_sr[11:8];
        tx_cnt++;
      end
      nbits = 0;
    end else if (adc_ncs) begin
      wcnt++;
    end
    adc_eoc  = adc_ncs && (wcnt >= eoc_delay) && !(tx_cnt - 1 == stuck_abs);
    ncs_prev = adc_ncs;
    sck_prev = adc_sck;
  end

  // Monitor
  logic  rd_stb = 1'b0;
  logic  stb_s;
  logic  in_scan = 1'b0;
  logic  mon_ncs_prev = 1'b1;
  logic  prev_done = 1'b0;
  logic  prev_err = 1'b0;
  scan_t cur = '{-2, -1};
  rd_t   mon_rd;
  int    busy_len = 0;
  int    since_done = 0;
  int    since_ncs = 0;
  int    done_cnt = 0;

  always @(posedge clock_mez) begin
    stb_s = rd_stb;
    #1;
    if (stb_s) begin
      if (rd_exp_q.size() == 0) fail_now("rd_data: no expectation");
      else begin
        mon_rd = rd_exp_q.pop_front();
        check($sformatf("rd_data[%0d]", mon_rd.addr), rd_data, mon_rd.val);
      end
    end
    if (adc_ncs && !mon_ncs_prev) since_ncs = 0;
    else since_ncs++;
    if (!nrst) begin
      if (in_scan && cur.len != -1) fail_now("scan_abort: scan cut by reset");
      in_scan = 1'b0;
    end else begin
      since_done++;
      if (!adc_ncs && mon_ncs_prev && !in_scan) begin
        if (exp_scan_q.size() == 0) begin
          fail_now("scan_start: unexpected scan");
          cur = '{-2, -1};
        end else begin
          cur = exp_scan_q.pop_front();
          if (cur.gap >= 0) check("restart_gap", since_done, cur.gap);
        end
        in_scan  = 1'b1;
        busy_len = 0;
      end
      if (in_scan && busy) busy_len++;
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 0);
        if (prev_done) fail_now("done_width: done longer than one cycle");
        if (!in_scan) fail_now("done: unexpected done");
        else if (cur.len >= 0) check("scan_len", busy_len, cur.len);
        in_scan    = 1'b0;
        since_done = 0;
      end
      if (err_tmo && !prev_err) begin
        if (exp_tmo_q.size() == 0) fail_now("tmo: unexpected timeout");
        else check("tmo_latency", since_ncs, exp_tmo_q.pop_front());
      end
    end
    mon_ncs_prev = adc_ncs;
    prev_done    = done;
    prev_err     = err_tmo;
  end

  // Reference model: scan duration from per-transaction phase lengths
  function automatic int scan_len(input int d, input int stuck_k);
    int total = 0;
    for (int k = 0; k <= NCH; k++) begin
      total += TX_BASE + ((k == stuck_k) ? EOC_TMO : ((d > EOC_MIN ? d : EOC_MIN) + 1 - EOC_MIN));
    end
    return total;
  endfunction

  task automatic expect_scan(input int gap, input int stuck_k);
    exp_scan_q.push_back('{scan_len(eoc_delay, stuck_k), gap});
    for (int k = 0; k <= NCH; k++) exp_cmd_q.push_back((k < NCH) ? k : 0);
  endtask

  task automatic pulse_start();
    @(negedge clock_mez);
    start = 1'b1;
    @(negedge clock_mez);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_scan_q.size() != 0 || in_scan) && n < 6000) begin
      @(negedge clock_mez);
      n++;
    end
    check({nm, "_completes"}, (n < 6000), 1);
  endtask

  task automatic rd_chk(input int a, input logic [11:0] v);
    @(negedge clock_mez);
    rd_addr = 4'(a);
    rd_exp_q.push_back('{a, v});
    rd_stb = 1'b1;
    @(negedge clock_mez);
    rd_stb = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) rd_chk(a, (a < NCH) ? exp_res[a] : 12'h000);
  endtask

  task automatic randomize_adc();
    for (int c = 0; c < 16; c++) adc_val[c] = 12'($urandom_range(0, 4095));
    eoc_delay = $urandom_range(0, 20);
  endtask

  task automatic commit_results();
    for (int c = 0; c < NCH; c++) exp_res[c] = adc_val[c];
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, base, n;
    nrst = 1'b0; start = 1'b0; continuous = 1'b0; err_clr = 1'b0; rd_addr = '0;
    for (int c = 0; c < 16; c++) begin
      adc_val[c] = '0;
      exp_res[c] = '0;
    end

    repeat (3) @(negedge clock_mez);
    check("rst_ncs", adc_ncs, 1);
    check("rst_sck", adc_sck, 0);
    check("rst_sdi", adc_sdi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_tmo, 0);
    check("rst_rd", rd_data, 0);
    nrst = 1'b1;
    read_all();

    for (int c = 0; c < 16; c++) adc_val[c] = 12'h100 + 12'(c);
    eoc_delay = 10;
    expect_scan(-1, -1);
    pulse_start();
    wait_idle("single");
    commit_results();
    read_all();

    repeat (4) begin
      randomize_adc();
      expect_scan(-1, -1);
      pulse_start();
      wait_idle("random");
      commit_results();
      read_all();
    end

    randomize_adc();
    stuck_abs = tx_cnt + 3;
    exp_tmo_q.push_back(EOC_MIN + EOC_TMO);
    expect_scan(-1, 3);
    pulse_start();
    wait_idle("timeout");
    commit_results();
    check("err_sticky", err_tmo, 1);
    @(negedge clock_mez) err_clr = 1'b1;
    @(negedge clock_mez) err_clr = 1'b0;
    check("err_cleared", err_tmo, 0);
    read_all();

    // err_clr held through a timeout: the set must still register
    randomize_adc();
    stuck_abs = tx_cnt + 7;
    exp_tmo_q.push_back(EOC_MIN + EOC_TMO);
    expect_scan(-1, 7);
    err_clr = 1'b1;
    pulse_start();
    wait_idle("tmo_vs_clr");
    err_clr = 1'b0;
    commit_results();
    stuck_abs = -100;
    check("err_clr_after", err_tmo, 0);

    randomize_adc();
    d0 = done_cnt;
    expect_scan(-1, -1);
    pulse_start();
    repeat ($urandom_range(20, 500)) @(negedge clock_mez);
    check("busy_mid_scan", busy, 1);
    pulse_start();
    wait_idle("start_busy");
    repeat (200) @(negedge clock_mez);
    check("start_busy_one_done", done_cnt - d0, 1);
    commit_results();
    read_all();

    randomize_adc();
    base = tx_cnt;
    exp_scan_q.push_back('{-1, -1});
    for (int k = 0; k < 5; k++) exp_cmd_q.push_back(k);
    pulse_start();
    n = 0;
    do begin
      @(posedge clock_mez);
      #2;
      n++;
    end while (!(tx_cnt == base + 5 && nbits == 6) && n < 3000);
    check("mid_shift_reached", (n < 3000), 1);
    nrst = 1'b0;
    @(posedge clock_mez);
    #1;
    check("abort_ncs", adc_ncs, 1);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clock_mez);
    nrst = 1'b1;
    for (int c = 0; c < 16; c++) exp_res[c] = '0;
    read_all();

    randomize_adc();
    d0 = done_cnt;
    continuous = 1'b1;
    expect_scan(-1, -1);
    expect_scan(1, -1);
    expect_scan(1, -1);
    pulse_start();
    n = 0;
    while (done_cnt < d0 + 2 && n < 8000) begin
      @(negedge clock_mez);
      n++;
    end
    check("cont_two_scans", (n < 8000), 1);
    repeat (100) @(negedge clock_mez);
    continuous = 1'b0;
    wait_idle("continuous");
    repeat (200) @(negedge clock_mez);
    check("cont_done_count", done_cnt - d0, 3);
    commit_results();
    read_all();

    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("tmo_queue_drained", exp_tmo_q.size(), 0);
    check("rd_queue_drained", rd_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
